// File: rtl/data_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Word-organised data memory behind a valid/ready request port,
//            with byte-masked stores and sized, sign/zero-extended loads.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_ld,
    input  logic              is_st,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] ld_result,
    output logic              err
);
    localparam int         c_bytes    = DATA_W / 8;
    localparam int         c_off_w    = $clog2(c_bytes);
    localparam int         c_idx_w    = $clog2(DEPTH);
    localparam logic [1:0] c_lat_last = 2'(RD_LAT - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [1:0]         r_cnt;
    logic [c_off_w-1:0] r_off;
    logic [1:0]         r_size;
    logic               r_uns;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  r_ld_result;
    logic               r_err;

    logic [c_idx_w-1:0] w_idx;
    logic [c_off_w-1:0] w_off;
    logic [2:0]         w_align;
    logic [7:0]         w_be_base;
    logic [c_bytes-1:0] w_be;
    logic               w_illegal;
    logic               w_accept;
    logic               w_has_resp;
    logic               w_ld_ok;
    logic               w_st_ok;
    logic [DATA_W-1:0]  w_wdata_sh;
    logic [DATA_W-1:0]  w_shifted;
    logic [63:0]        w_sh64;
    logic [63:0]        w_ext64;
    logic               w_sign;
    logic               w_unused;

    // Upper address bits are deliberately ignored so accesses wrap around the array.
    assign w_idx = addr[c_off_w +: c_idx_w];
    assign w_off = addr[c_off_w-1:0];

    always_comb begin
        w_align   = 3'b111;
        w_be_base = 8'hFF;
        case (size)
            2'b00:   begin w_align = 3'b000; w_be_base = 8'h01; end
            2'b01:   begin w_align = 3'b001; w_be_base = 8'h03; end
            2'b10:   begin w_align = 3'b011; w_be_base = 8'h0F; end
            default: begin w_align = 3'b111; w_be_base = 8'hFF; end
        endcase
    end

    assign w_illegal  = (is_ld & is_st)
                      | ((size == 2'b11) & (DATA_W == 32))
                      | (|(addr[2:0] & w_align));
    assign w_accept   = req_valid & req_ready;
    assign w_has_resp = w_accept & (is_ld | is_st);
    assign w_ld_ok    = w_accept & is_ld & ~w_illegal;
    assign w_st_ok    = w_accept & is_st & ~w_illegal;
    assign w_be       = w_be_base[c_bytes-1:0] << w_off;
    assign w_wdata_sh = wdata << {w_off, 3'b000};

    // Storage and the registered read are not reset; unwritten words read as X.
    always_ff @(posedge clk) begin
        if (w_st_ok) begin
            for (int b = 0; b < c_bytes; b++) begin
                if (w_be[b]) begin
                    mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
                end
            end
        end
        if (w_ld_ok) begin
            r_rdata <= mem[w_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (w_has_resp) w_next = w_ld_ok ? c_busy : c_resp;
            c_busy:  if (r_cnt == c_lat_last) w_next = c_resp;
            c_resp:  if (resp_ready) w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    // Gating with rst_n keeps requests from being taken (and stores written) while in reset.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            c_idle:  req_ready  = rst_n;
            c_resp:  resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_off       <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            r_ld_result <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_off  <= w_off;
                r_size <= size;
                r_uns  <= ld_unsigned;
                r_cnt  <= '0;
            end
            if (w_has_resp) begin
                r_err       <= w_illegal;
                r_ld_result <= '0;
            end
            if (r_state == c_busy) begin
                if (r_cnt == c_lat_last) begin
                    r_ld_result <= w_ext64[DATA_W-1:0];
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end
        end
    end

    // Extension is done at 64 bits so the same code serves both data widths.
    assign w_shifted = r_rdata >> {r_off, 3'b000};
    assign w_sh64    = 64'(w_shifted);

    always_comb begin
        w_sign  = 1'b0;
        w_ext64 = w_sh64;
        case (r_size)
            2'b00: begin
                w_sign  = ~r_uns & w_sh64[7];
                w_ext64 = {{56{w_sign}}, w_sh64[7:0]};
            end
            2'b01: begin
                w_sign  = ~r_uns & w_sh64[15];
                w_ext64 = {{48{w_sign}}, w_sh64[15:0]};
            end
            2'b10: begin
                w_sign  = ~r_uns & w_sh64[31];
                w_ext64 = {{32{w_sign}}, w_sh64[31:0]};
            end
            default: w_ext64 = w_sh64;
        endcase
    end

    assign ld_result = r_ld_result;
    assign err       = r_err;

    assign w_unused = ^{addr[31:c_off_w+c_idx_w], w_ext64};

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Scoreboard bench for data_mem_ctrl (DATA_W=32, RD_LAT=3).
// Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_ctrl;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 1024;
    localparam int RD_LAT    = 3;
    localparam int BYTE_SPAN = DEPTH * (DATA_W / 8);
    localparam int LIMIT     = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              is_ld = 1'b0;
    logic              is_st = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              ld_unsigned = 1'b0;
    logic [31:0]       addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              resp_ready = 1'b0;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] ld_result;
    logic              err;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl [BYTE_SPAN];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .is_ld       (is_ld),
        .is_st       (is_st),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .addr        (addr),
        .wdata       (wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .ld_result   (ld_result),
        .err         (err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit mdl_illegal(bit ld, bit st, logic [1:0] sz, logic [31:0] a);
        int am;
        am = (1 << sz) - 1;
        return (ld && st) || (sz == 2'd3 && DATA_W == 32) || ((int'(a[2:0]) & am) != 0);
    endfunction

    function automatic logic [DATA_W-1:0] mdl_load(logic [1:0] sz, bit uns, logic [31:0] a);
        logic [63:0] v;
        int          nb;
        v  = '0;
        nb = 1 << sz;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[int'((a + i) % BYTE_SPAN)];
        if (!uns && v[8*nb-1]) begin
            for (int i = 8 * nb; i < 64; i++) v[i] = 1'b1;
        end
        return v[DATA_W-1:0];
    endfunction

    task automatic do_req(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [DATA_W-1:0] wd, input int hold,
                          output logic [DATA_W-1:0] got);
        bit   bad;
        bit   has_resp;
        int   lat;
        exp_t e;
        got      = '0;
        bad      = mdl_illegal(ld, st, sz, a);
        has_resp = ld || st;
        @(negedge clk);
        check_val("idle_ready", req_ready, 1);
        req_valid = 1'b1; is_ld = ld; is_st = st; size = sz; ld_unsigned = uns; addr = a; wdata = wd;
        e.err  = has_resp && bad;
        e.data = (ld && !bad) ? mdl_load(sz, uns, a) : '0;
        if (st && !bad) begin
            for (int i = 0; i < (1 << sz); i++) mdl[int'((a + i) % BYTE_SPAN)] = wd[8*i +: 8];
        end
        if (has_resp) sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0; addr = $urandom; wdata = $urandom; size = 2'($urandom);
        if (!has_resp) begin
            for (int i = 0; i < RD_LAT + 2; i++) begin
                check_val("nop_no_resp", resp_valid, 0);
                @(negedge clk);
            end
            check_val("nop_ready", req_ready, 1);
            return;
        end
        check_val("busy_not_ready", req_ready, 0);
        lat = 0;
        while (!resp_valid && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        check_val("latency", lat, (ld && !bad) ? RD_LAT : 0);
        if (!resp_valid) begin
            void'(sb.pop_front());
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check_val("hold_valid", resp_valid, 1);
            check_val("hold_data", ld_result, sb[0].data);
            check_val("hold_err", err, sb[0].err);
            check_val("hold_not_ready", req_ready, 0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        e = sb.pop_front();
        check_val("resp_valid", resp_valid, 1);
        check_val("resp_err", err, e.err);
        check_val("resp_data", ld_result, e.data);
        got = ld_result;
        @(negedge clk);
        resp_ready = 1'b0;
        check_val("resp_done", resp_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] got;
        int                op;
        bit                rl;
        bit                rs;
        logic [1:0]        rsz;
        logic [31:0]       ra;

        #2 rst_n = 1'b0;
        #1;
        check_val("rst_resp_valid", resp_valid, 0);
        check_val("rst_err", err, 0);
        check_val("rst_ld_result", ld_result, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_req_ready", req_ready, 1);

        do_req(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, got);
        do_req(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, got);
        check_val("word_deadbeef", got, 32'hDEADBEEF);

        do_req(0, 1, 2'd2, 0, 32'h10, 32'h0, 0, got);
        do_req(0, 1, 2'd0, 0, 32'h13, 32'h80, 0, got);
        do_req(1, 0, 2'd0, 0, 32'h13, 32'h0, 0, got);
        check_val("byte_signed", got, 32'hFFFFFF80);
        do_req(1, 0, 2'd0, 1, 32'h13, 32'h0, 0, got);
        check_val("byte_unsigned", got, 32'h00000080);
        do_req(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, got);
        check_val("word_after_byte", got, 32'h80000000);

        do_req(1, 0, 2'd1, 0, 32'h11, 32'h0, 0, got);
        check_val("misaligned_zero", got, 32'h0);
        do_req(1, 1, 2'd2, 0, 32'h10, 32'h12345678, 0, got);
        do_req(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, got);
        check_val("no_write_on_err", got, 32'h80000000);

        do_req(0, 1, 2'd2, 0, 32'h1010, 32'hCAFEF00D, 0, got);
        do_req(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, got);
        check_val("alias_load", got, 32'hCAFEF00D);

        do_req(1, 0, 2'd2, 0, 32'h10, 32'h0, 5, got);
        do_req(0, 0, 2'd2, 0, 32'h10, 32'hFFFFFFFF, 0, got);
        do_req(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, got);
        check_val("nop_no_write", got, 32'hCAFEF00D);
        do_req(1, 0, 2'd3, 0, 32'h18, 32'h0, 0, got);

        do_req(0, 1, 2'd2, 0, 32'h20, 32'h0, 0, got);
        do_req(0, 1, 2'd1, 0, 32'h22, 32'h8001, 1, got);
        do_req(1, 0, 2'd1, 0, 32'h22, 32'h0, 0, got);
        check_val("half_signed", got, 32'hFFFF8001);
        do_req(1, 0, 2'd1, 1, 32'h22, 32'h0, 0, got);
        check_val("half_unsigned", got, 32'h00008001);
        do_req(1, 0, 2'd2, 0, 32'h20, 32'h0, 0, got);
        check_val("word_after_half", got, 32'h80010000);

        // Abort a load mid-flight: it must never respond.
        @(negedge clk);
        req_valid = 1'b1; is_ld = 1'b1; is_st = 1'b0; size = 2'd2; ld_unsigned = 1'b0; addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        check_val("abort_busy", req_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_resp_valid", resp_valid, 0);
        check_val("abort_err", err, 0);
        check_val("abort_ld_result", ld_result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < RD_LAT + 3; i++) begin
            check_val("abort_no_resp", resp_valid, 0);
            @(negedge clk);
        end
        check_val("abort_ready", req_ready, 1);
        do_req(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, got);
        check_val("abort_next_load", got, 32'hCAFEF00D);

        for (int w = 0; w < 16; w++) do_req(0, 1, 2'd2, 0, 32'(w * 4), $urandom, 0, got);
        for (int k = 0; k < 40; k++) begin
            op  = $urandom_range(0, 9);
            rl  = (op <= 4) || (op == 9);
            rs  = (op >= 5 && op <= 7) || (op == 9);
            rsz = 2'($urandom_range(0, 3));
            ra  = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12);
            do_req(rl, rs, rsz, bit'($urandom_range(0, 1)), ra, $urandom, $urandom_range(0, 2), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
